// File: rtl/fir_err_monitor.sv
// fir_err_monitor
//   Compares the approximate-adder FIR output against the exact-adder FIR
//   output over a programmable window of samples. It accumulates the
//   saturating sum of |approx-exact|, the maximum |approx-exact| and the
//   count of samples that differ. Results are held until the next start.
//
//   Optional build macro: FIR_ERR_SQ_EN adds sum_sq_err, the saturating
//   sum of squared absolute errors.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   start        one-cycle pulse, begins a window (only honoured in IDLE)
//   win_len      samples per window, latched on start (0 behaves as 1)
//   in_valid     approx_data/exact_data valid (only used in RUN)
//   approx_data  approximate FIR output, unsigned
//   exact_data   exact FIR output, unsigned
//   busy         high in RUN and DRAIN
//   done         one-cycle pulse once results are final
//   sum_abs_err  saturating sum of |approx-exact|
//   max_abs_err  maximum |approx-exact| in the window
//   err_count    number of samples with approx != exact
//   sum_sq_err   (FIR_ERR_SQ_EN only) saturating sum of |approx-exact|^2
module fir_err_monitor #(
  parameter int DW    = 16,
  parameter int SUM_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   win_len,
  input  logic               in_valid,
  input  logic [DW-1:0]      approx_data,
  input  logic [DW-1:0]      exact_data,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   sum_abs_err,
  output logic [DW-1:0]      max_abs_err,
`ifdef FIR_ERR_SQ_EN
  output logic [CNT_W-1:0]   err_count,
  output logic [2*DW+CNT_W-1:0] sum_sq_err
`else
  output logic [CNT_W-1:0]   err_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_len, r_cnt;
  logic              r_s1_valid;
  logic [DW-1:0]     r_abs;
  logic [SUM_W-1:0]  r_sum;
  logic [DW-1:0]     r_max;
  logic [CNT_W-1:0]  r_err;

  logic              w_start, w_accept, w_last;
  logic signed [DW:0] w_diff;
  logic [DW-1:0]     w_abs;
  logic [SUM_W:0]    w_sum_ext;
  logic [SUM_W-1:0]  w_sum_nxt;

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_accept = (r_state == S_RUN) && in_valid;
  assign w_last   = w_accept && ((r_cnt + CNT_W'(1)) == r_len);

  // Zero-extended operands keep the subtraction unsigned; the magnitude of a
  // (DW+1)-bit difference of two DW-bit values always fits in DW bits.
  assign w_diff = $signed({1'b0, approx_data}) - $signed({1'b0, exact_data});
  assign w_abs  = DW'(w_diff[DW] ? -w_diff : w_diff);

  // Saturating accumulate: the extra carry bit flags overflow.
  assign w_sum_ext = {1'b0, r_sum} + (SUM_W+1)'(r_abs);
  assign w_sum_nxt = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];

`ifdef FIR_ERR_SQ_EN
  localparam int SQ_W = 2*DW + CNT_W;
  logic [SQ_W-1:0]   r_sq;
  logic [2*DW-1:0]   w_abs_w, w_sq;
  logic [SQ_W:0]     w_sq_ext;
  logic [SQ_W-1:0]   w_sq_nxt;

  assign w_abs_w  = {{DW{1'b0}}, r_abs};
  assign w_sq     = w_abs_w * w_abs_w;
  assign w_sq_ext = {1'b0, r_sq} + (SQ_W+1)'(w_sq);
  assign w_sq_nxt = w_sq_ext[SQ_W] ? '1 : w_sq_ext[SQ_W-1:0];
  assign sum_sq_err = r_sq;
`endif

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_abs      <= '0;
      r_sum      <= '0;
      r_max      <= '0;
      r_err      <= '0;
`ifdef FIR_ERR_SQ_EN
      r_sq       <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_s1_valid <= w_accept;
      if (w_accept) r_abs <= w_abs;
      if (w_start) begin
        r_len <= (win_len == '0) ? CNT_W'(1) : win_len;
        r_cnt <= '0;
        r_sum <= '0;
        r_max <= '0;
        r_err <= '0;
`ifdef FIR_ERR_SQ_EN
        r_sq  <= '0;
`endif
      end else begin
        if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
        // Stage 2: the sample registered on the previous edge is folded in.
        if (r_s1_valid) begin
          r_sum <= w_sum_nxt;
          if (r_abs > r_max) r_max <= r_abs;
          if (r_abs != '0) r_err <= r_err + CNT_W'(1);
`ifdef FIR_ERR_SQ_EN
          r_sq  <= w_sq_nxt;
`endif
        end
      end
    end
  end

  assign sum_abs_err = r_sum;
  assign max_abs_err = r_max;
  assign err_count   = r_err;

endmodule

// File: doc/fir_err_monitor.md
Name: fir_err_monitor

Overview:
- Downstream of the 16-bit shift-coefficient FIR. Consumes the approximate-adder FIR output and the exact-adder FIR output on the same cycle.
- Over a programmable window of samples it accumulates error metrics for characterising the approximate adders: sum of absolute error, maximum absolute error, and count of erroneous samples.
- Results are held for readout by the testbench or a debug register stage.

Parameters:
- DW, 16, data width of both FIR outputs.
- SUM_W, 32, width of the absolute-error accumulator.
- CNT_W, 16, width of the window length and sample counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a measurement window (honoured only in IDLE).
- win_len  in  CNT_W  number of samples in the window; sampled on start; 0 is treated as 1.
- in_valid  in  1  approx_data/exact_data are valid this cycle.
- approx_data  in  DW  approximate FIR output, unsigned.
- exact_data  in  DW  exact FIR output, unsigned.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when results become valid.
- sum_abs_err  out  SUM_W  saturating sum of |approx-exact|.
- max_abs_err  out  DW  maximum |approx-exact| in the window.
- err_count  out  CNT_W  number of samples with approx != exact.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sum_abs_err=0, max_abs_err=0, err_count=0; internal counters and pipeline registers cleared.
- Reset mid-window aborts the measurement with no done pulse.
- States:
  - IDLE: on start, latch win_len (0 -> 1), clear all result registers and the sample counter, go to RUN.
  - RUN: a sample is accepted on each edge with in_valid=1. Accepting sample number win_len goes to DRAIN.
  - DRAIN: exactly 1 cycle, then DONE.
  - DONE: done=1 for this cycle only, then IDLE.
- start outside IDLE is ignored. in_valid outside RUN is ignored.
- Pipeline stage 1 (on the accepting edge):
  - diff = {1'b0,approx} - {1'b0,exact}, DW+1 bits signed.
  - abs_err = |diff|, fits DW bits.
  - Register abs_err and a valid flag.
- Stage 2 (next edge):
  - sum_abs_err += abs_err, saturating at 2^SUM_W-1, never wraps.
  - max_abs_err = max(max_abs_err, abs_err).
  - err_count += (abs_err != 0).
- Latency: last sample accepted at edge k. Its contribution is applied at edge k+1, together with the DRAIN -> DONE transition. done is high during the cycle after edge k+1 and results are final at that point.
- Results are held unchanged in IDLE until the next accepted start, which clears them.
- busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
- in_valid gaps in RUN simply stall; there is no timeout.
- Arithmetic uses unsigned operands only. Identical inputs give abs_err=0 and do not increment err_count.

Optional Feature:
- Macro FIR_ERR_SQ_EN.
- When defined:
  - Adds output sum_sq_err, width 2*DW+CNT_W.
  - Accumulates abs_err*abs_err in stage 2 with the same timing, saturation and clear rules as sum_abs_err.
  - Reset value 0.
- When undefined: the port and the multiplier are absent; all other behaviour is identical.

Test Plan:
- Reset, then 5 idle cycles -> all outputs 0, busy=0, no done.
- Window of 4 with continuous in_valid, approx={100,200,300,400}, exact={100,198,305,400} -> done 2 cycles after the 4th sample edge, sum_abs_err=7, max_abs_err=5, err_count=2; with FIR_ERR_SQ_EN, sum_sq_err=29.
- Window of 3 with in_valid gaps (valid, 2 idle, valid, idle, valid), approx=0xFFFF, exact=0x0000 each time -> sum=196605, max=65535, err_count=3, done only after the 3rd valid; start pulsed mid-run is ignored.
- Saturation with SUM_W=17, window of 3, approx=0xFFFF, exact=0 -> sum_abs_err=131071, held at saturation and not wrapped.
- win_len=0 with one valid sample approx=10, exact=12 -> treated as 1: sum=2, max=2, err_count=1. Then rst asserted for one cycle in the middle of the next window -> all outputs 0, IDLE, no done.
